// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter with bounded burst locking onto one single-port RAM.
// Latency: grant and RAM port are combinational; read data returns one cycle after acceptance.
// Backpressure: mN_ready holds off the losing requester; responses have no backpressure.
`timescale 1ns/1ps
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_data,

    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_data,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Arbitration state: round-robin pointer, lock ownership and burst length
    logic          last_grant_q,  last_grant_d;
    logic          lock_active_q, lock_active_d;
    logic          lock_holder_q, lock_holder_d;
    logic [CW-1:0] burst_cnt_q,   burst_cnt_d;
    // Outstanding read response tag
    logic          pend_valid_q,  pend_valid_d;
    logic          pend_id_q,     pend_id_d;

    logic                  gnt_vld;
    logic                  gnt_id;
    logic                  holder_valid;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Pick the winner: an unexhausted lock first, then a lone requester, then round-robin
    always_comb begin
        gnt_vld      = 1'b0;
        gnt_id       = 1'b0;
        holder_valid = lock_holder_q ? m1_valid : m0_valid;
        if (rst_n) begin
            if (lock_active_q && holder_valid && (burst_cnt_q < CNT_MAX)) begin
                gnt_vld = 1'b1;
                gnt_id  = lock_holder_q;
            end else if (m0_valid && !m1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (m1_valid && !m0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end else if (m0_valid && m1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant_q;
            end
        end
    end

    // Route the winning request onto the RAM port; idle port is driven to zero
    always_comb begin
        sel_we    = gnt_id ? m1_we    : m0_we;
        sel_lock  = gnt_id ? m1_lock  : m0_lock;
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;

        m0_ready  = gnt_vld && !gnt_id;
        m1_ready  = gnt_vld &&  gnt_id;
        bram_en   = gnt_vld;
        bram_we   = gnt_vld && sel_we;
        bram_addr = gnt_vld ? sel_addr  : '0;
        bram_di   = gnt_vld ? sel_wdata : '0;
    end

    // Next-state: pointer follows the grant, lock counts consecutive locked grants and saturates
    always_comb begin
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        lock_holder_d = lock_holder_q;
        burst_cnt_d   = burst_cnt_q;
        pend_valid_d  = gnt_vld && !sel_we;
        pend_id_d     = gnt_vld ? gnt_id : pend_id_q;

        if (gnt_vld) begin
            last_grant_d = gnt_id;
            if (sel_lock) begin
                if (lock_active_q && (lock_holder_q == gnt_id) && (burst_cnt_q < CNT_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CNT_ONE;
                end else begin
                    // New holder, or an exhausted holder re-granted because the other side is idle
                    burst_cnt_d   = CNT_ONE;
                    lock_active_d = 1'b1;
                    lock_holder_d = gnt_id;
                end
            end else begin
                lock_active_d = 1'b0;
                burst_cnt_d   = '0;
            end
        end else begin
            lock_active_d = 1'b0;
            burst_cnt_d   = '0;
        end
    end

    // State registers; reset makes requester 0 win the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            lock_active_q <= 1'b0;
            lock_holder_q <= 1'b0;
            burst_cnt_q   <= '0;
            pend_valid_q  <= 1'b0;
            pend_id_q     <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            lock_holder_q <= lock_holder_d;
            burst_cnt_q   <= burst_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_id_q     <= pend_id_d;
        end
    end

    // Read data is broadcast; the valid strobe tags which requester owns it
    always_comb begin
        m0_rsp_valid = pend_valid_q && !pend_id_q;
        m1_rsp_valid = pend_valid_q &&  pend_id_q;
        m0_rsp_data  = bram_dout;
        m1_rsp_data  = bram_dout;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter that shares one single-port block RAM between two masters. It accepts one read or write per cycle from requester 0 or 1 using round-robin priority, with optional bounded burst locking, and drives the RAM port directly. Read data returns to the requester that issued the read, one cycle after acceptance. It sits between two datapath clients and the `bram_single_port` instance, with matching DATA_WIDTH and ADDR_WIDTH.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- MAX_BURST, 4, maximum consecutive locked grants to one requester (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_valid  in  1  request valid (N = 0, 1)
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  request to keep the grant on the next cycle
- mN_addr  in  ADDR_WIDTH  request address
- mN_wdata  in  DATA_WIDTH  write data
- mN_ready  out  1  request accepted this cycle
- mN_rsp_valid  out  1  read data valid
- mN_rsp_data  out  DATA_WIDTH  read data
- bram_en  out  1  to RAM en
- bram_we  out  1  to RAM we
- bram_addr  out  ADDR_WIDTH  to RAM addr
- bram_di  out  DATA_WIDTH  to RAM di
- bram_dout  in  DATA_WIDTH  from RAM dout

## Operation
- A transfer occurs on a cycle where mN_valid && mN_ready. At most one mN_ready is high per cycle.
- mN_ready is combinational from the valids and the internal state. It never depends on itself.
- Requesters must hold valid, we, addr and wdata stable until accepted.
- Grant selection, in priority order:
  - **Lock hold.** If lock_active, the holder's valid is 1, and burst_cnt < MAX_BURST, grant the holder.
  - **Single requester.** If exactly one valid is 1, grant it. If the lock was exhausted and the other requester is idle, the holder may be granted again; the counter restarts at 1.
  - **Both valid.** Grant the requester other than last_grant.
  - **None valid.** Grant nothing.
- RAM port outputs:
  - When a grant is given: bram_en=1, and bram_we/addr/di are copied from the granted requester.
  - Otherwise: bram_en=0, bram_we=0, bram_addr=0, bram_di=0.
- State updates on each grant:
  - last_grant takes the granted index.
  - If the granted mN_lock=1:
    - Same holder as the previous cycle and lock_active: burst_cnt increments.
    - Otherwise: burst_cnt=1 and lock_active=1 with the new holder.
  - If the granted mN_lock=0: lock_active=0 and burst_cnt=0.
- Lock release:
  - The cycle after burst_cnt reaches MAX_BURST, the lock is void. If both requesters are valid, the other requester wins.
  - A cycle with no grant clears lock_active and burst_cnt.
- Read response:
  - On an accepted read, pend_valid=1 and pend_id=N are registered.
  - The next cycle, mN_rsp_valid=1 for N=pend_id, and mN_rsp_data = bram_dout.
  - Writes produce no response.
  - There is no response backpressure; requesters must always sink responses.
- mN_rsp_data is driven from bram_dout at all times. It is meaningful only when rsp_valid is high.
- Read-after-write to the same address on consecutive cycles returns the new data. The RAM guarantees this and the arbiter adds no hazard logic.

## Timing
- Reset values: last_grant=1 (so requester 0 wins the first contention), lock_active=0, burst_cnt=0, pend_valid=0. All mN_rsp_valid=0.
- The RAM port outputs are combinational and idle while rst_n=0.
- Read latency: accepted at edge k, rsp_valid high during cycle k+1 for exactly one cycle.
- Throughput: one access per cycle. Back-to-back reads from alternating requesters produce alternating responses, each tagged correctly.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 immediately), and the lock and pointer return to their reset values.
- Width of burst_cnt: clog2(MAX_BURST+1) bits. It saturates and never wraps.

## Test plan
- **Reset.** Hold rst_n=0 with both valids high → ready=0, bram_en=0, rsp_valid=0. Release reset with both requesting reads → m0 is granted first, then m1, alternating.
- **Write then read.** m0 writes 0xBEEF to address 0x12, then reads 0x12 → the cycle after the read, m0_rsp_valid=1 with data 0xBEEF, and m1_rsp_valid stays 0.
- **Contention.** Both requesters issue continuous reads of addresses 0x00 and 0x01, which were preloaded with 0x1111 and 0x2222 → strict alternation, and every response carries the correct data on the correct port.
- **Burst lock.** m0 holds lock=1 and valid=1 for 10 cycles while m1 is valid → m0 is granted 4 cycles, then m1 for 1 cycle, then m0 for 4, and so on.
- **Lock with idle competitor.** m0 is locked and m1 is idle → m0 is granted every cycle. Deasserting m0_lock while m1 is valid → m1 is granted on the next contention.
- **Mid-flight reset.** Assert rst_n=0 in the cycle after an accepted read → rsp_valid=0 and the pointer resets, so m0 wins the next contention.
